// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer.
//   state_t   : FSM state encoding (IDLE, SHIFT, FIN)
//   DIR_LEFT  : shift direction code for left shifts
//   DIR_RIGHT : shift direction code for right shifts
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_stage.sv
// One combinational barrel-shifter stage: shifts i_data by i_amt (a power of
// two) when enabled, otherwise passes the data through unchanged.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (adds i_rot, rotate mode).
// Ports:
//   i_data : operand
//   i_amt  : stage shift distance (2^k)
//   i_dir  : DIR_LEFT / DIR_RIGHT
//   i_fill : bit shifted into vacated positions on right shifts
//   i_en   : apply this stage (latched AMT[k])
//   i_rot  : rotate instead of shift (only with SHIFT_SEQ_ROTATE_EN)
//   o_data : stage result
module shift_stage
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [AMT_W-1:0] i_amt,
    input  logic             i_dir,
    input  logic             i_fill,
    input  logic             i_en,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             i_rot,
`endif
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_left;
    logic [WIDTH-1:0] w_right;
    logic [WIDTH-1:0] w_fill_mask;

    assign w_left      = i_data << i_amt;
    assign w_right     = i_data >> i_amt;
    // Ones in the top i_amt positions: exactly the bits a right shift vacates.
    assign w_fill_mask = ~({WIDTH{1'b1}} >> i_amt);

`ifdef SHIFT_SEQ_ROTATE_EN
    logic [AMT_W:0]   w_comp;
    logic [WIDTH-1:0] w_wrap_l;
    logic [WIDTH-1:0] w_wrap_r;

    // Bits that fall off one end re-enter at the other.
    assign w_comp   = (AMT_W+1)'(WIDTH) - {1'b0, i_amt};
    assign w_wrap_l = i_data >> w_comp;
    assign w_wrap_r = i_data << w_comp;
`endif

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_dir)
                DIR_LEFT:  o_data = w_left;
                DIR_RIGHT: o_data = w_right | (i_fill ? w_fill_mask : '0);
            endcase
`ifdef SHIFT_SEQ_ROTATE_EN
            if (i_rot)
                o_data = (i_dir == DIR_RIGHT) ? (w_right | w_wrap_r) : (w_left | w_wrap_l);
`endif
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter. One log2 stage is applied per clock, largest
// stage first, so every operation takes AMT_W SHIFT cycles plus one FIN cycle
// that pulses DONE.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (adds ROT input for rotates).
// Ports:
//   CLK, RST : clock, synchronous active-high reset
//   START    : accept a new operation (IDLE only)
//   SH_DIR   : 1 = right, 0 = left
//   ARITH    : sign-fill on right shifts
//   AMT      : shift distance 0..WIDTH-1
//   INPUT    : operand
//   ROT      : rotate in SH_DIR direction (only with SHIFT_SEQ_ROTATE_EN)
//   BUSY     : high while shifting
//   DONE     : one-cycle pulse, OUTPUT valid
//   OUTPUT   : result register, held until the next accepted START
module shift_sequencer
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SH_DIR,
    input  logic             ARITH,
    input  logic [AMT_W-1:0] AMT,
    input  logic [WIDTH-1:0] INPUT,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             ROT,
`endif
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] OUTPUT
);

    localparam int K_W = $clog2(AMT_W);

    state_t           r_state;
    logic [K_W-1:0]   r_k;
    logic [AMT_W-1:0] r_amt;
    logic             r_dir;
    logic             r_fill;
    logic [AMT_W-1:0] w_stage_amt;
    logic [WIDTH-1:0] w_stage_out;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic             r_rot;
`endif

    assign w_stage_amt = AMT_W'(1) << r_k;

    shift_stage #(.WIDTH(WIDTH)) u_stage (
        .i_data (OUTPUT),
        .i_amt  (w_stage_amt),
        .i_dir  (r_dir),
        .i_fill (r_fill),
        .i_en   (r_amt[r_k]),
`ifdef SHIFT_SEQ_ROTATE_EN
        .i_rot  (r_rot),
`endif
        .o_data (w_stage_out)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            OUTPUT  <= '0;
            r_k     <= '0;
            r_amt   <= '0;
            r_dir   <= 1'b0;
            r_fill  <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            r_rot   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        OUTPUT  <= INPUT;
                        r_amt   <= AMT;
                        r_dir   <= SH_DIR;
                        // The sign bit never changes while shifting right,
                        // so one latched fill bit serves every stage.
                        r_fill  <= SH_DIR & ARITH & INPUT[WIDTH-1];
`ifdef SHIFT_SEQ_ROTATE_EN
                        r_rot   <= ROT;
`endif
                        r_k     <= K_W'(AMT_W-1);
                        r_state <= SHIFT;
                        BUSY    <= 1'b1;
                    end
                end
                SHIFT: begin
                    OUTPUT <= w_stage_out;
                    if (r_k == '0) begin
                        r_state <= FIN;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                    end else begin
                        r_k <= r_k - K_W'(1);
                    end
                end
                FIN: begin
                    DONE    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    BUSY    <= 1'b0;
                    DONE    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        SH_DIR;
    logic        ARITH;
    logic [4:0]  AMT;
    logic [31:0] INPUT;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic        ROT;
`endif
    logic        BUSY;
    logic        DONE;
    logic [31:0] OUTPUT;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    shift_sequencer #(.WIDTH(32)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .SH_DIR (SH_DIR),
        .ARITH  (ARITH),
        .AMT    (AMT),
        .INPUT  (INPUT),
`ifdef SHIFT_SEQ_ROTATE_EN
        .ROT    (ROT),
`endif
        .BUSY   (BUSY),
        .DONE   (DONE),
        .OUTPUT (OUTPUT)
    );

    function automatic logic [31:0] model(input logic dir, input logic arith,
                                          input logic [4:0] amt, input logic [31:0] d);
        if (!dir)
            return d << amt;
        else if (arith)
            return 32'($signed(d) >>> amt);
        else
            return d >> amt;
    endfunction

    // Issue one op, push its expected result, then watch for DONE.
    // lat = negedge samples after the START edge until DONE is seen (5 means
    // DONE is high for the cycle sampled at START edge + 6).
    task automatic run_op(input logic dir, input logic arith, input logic [4:0] amt,
                          input logic [31:0] data, input logic poke,
                          output logic [31:0] got, output int lat, output int busy_n);
        logic [31:0] e;
        @(negedge CLK);
        START = 1'b1; SH_DIR = dir; ARITH = arith; AMT = amt; INPUT = data;
        e = model(dir, arith, amt, data);
`ifdef SHIFT_SEQ_ROTATE_EN
        if (ROT)
            e = dir ? ((data >> amt) | (data << (6'd32 - {1'b0, amt})))
                    : ((data << amt) | (data >> (6'd32 - {1'b0, amt})));
`endif
        exp_q.push_back(e);
        @(negedge CLK);
        // Scramble the operands after capture; they must be ignored.
        START = 1'b0; SH_DIR = ~dir; ARITH = ~arith; AMT = 5'($urandom); INPUT = $urandom;
        got = 'x; lat = -1; busy_n = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge CLK);
            if (poke) START = (c == 1 || c == 3 || c == 5);
            if (BUSY) busy_n++;
            if (DONE) begin
                got = OUTPUT; lat = c;
                break;
            end
        end
        START = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; START = 1'b0; SH_DIR = 1'b0; ARITH = 1'b0; AMT = '0; INPUT = '0;
`ifdef SHIFT_SEQ_ROTATE_EN
        ROT = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        START = 1'b1; INPUT = 32'h1234_5678;   // reset outranks START
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", DONE); end
        checks++; if (OUTPUT !== 32'h0) begin errors++; $display("FAIL reset_output got %h want 0", OUTPUT); end
        START = 1'b0; RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_left();
        logic [31:0] got, e;
        int lat, bn;
        run_op(1'b0, 1'b0, 5'd8, 32'h0000_00FF, 1'b0, got, lat, bn);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL left_result got %h want %h", got, e); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL left_latency got %0d want 5", lat); end
        // Result must hold through IDLE while inputs wiggle.
        repeat (3) begin
            @(negedge CLK);
            INPUT = $urandom; AMT = 5'($urandom);
        end
        checks++; if (OUTPUT !== e) begin errors++; $display("FAIL left_hold got %h want %h", OUTPUT, e); end
    endtask

    task automatic test_right();
        logic [31:0] got, e;
        int lat, bn;
        run_op(1'b1, 1'b1, 5'd31, 32'h8000_0000, 1'b0, got, lat, bn);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL arith_right got %h want %h", got, e); end
        run_op(1'b1, 1'b0, 5'd31, 32'h8000_0000, 1'b0, got, lat, bn);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL logic_right got %h want %h", got, e); end
        run_op(1'b1, 1'b1, 5'd4, 32'h7000_0000, 1'b0, got, lat, bn);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL arith_pos got %h want %h", got, e); end
    endtask

    task automatic test_amt0();
        logic [31:0] got, e;
        int lat, bn;
        run_op(1'b0, 1'b0, 5'd0, 32'hDEAD_BEEF, 1'b0, got, lat, bn);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL amt0_result got %h want %h", got, e); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL amt0_latency got %0d want 5", lat); end
        checks++; if (bn !== 5) begin errors++; $display("FAIL amt0_busy_cycles got %0d want 5", bn); end
    endtask

    task automatic test_ignore_start();
        logic [31:0] got, e;
        int lat, bn, extra;
        run_op(1'b0, 1'b0, 5'd3, 32'h0000_0011, 1'b1, got, lat, bn);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL ignore_result got %h want %h", got, e); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL ignore_latency got %0d want 5", lat); end
        extra = 0;
        repeat (10) begin
            @(negedge CLK);
            if (DONE || BUSY) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_extra_activity got %0d want 0", extra); end
        checks++; if (OUTPUT !== e) begin errors++; $display("FAIL ignore_hold got %h want %h", OUTPUT, e); end
    endtask

    task automatic test_mid_reset();
        int dones;
        @(negedge CLK);
        START = 1'b1; SH_DIR = 1'b0; ARITH = 1'b0; AMT = 5'd1; INPUT = 32'hFFFF_0000;
        @(negedge CLK);             // after edge N
        START = 1'b0;
        @(negedge CLK);             // after N+1
        @(negedge CLK);             // after N+2
        RST = 1'b1;                 // sampled at N+3
        @(negedge CLK);
        RST = 1'b0;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", BUSY); end
        checks++; if (OUTPUT !== 32'h0) begin errors++; $display("FAIL midrst_output got %h want 0", OUTPUT); end
        dones = 0;
        repeat (10) begin
            if (DONE) dones++;
            @(negedge CLK);
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_done got %0d want 0", dones); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, e;
        int lat, bn;
        run_op(1'b1, 1'b0, 5'd16, 32'hCAFE_0000, 1'b0, got, lat, bn);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL b2b_first got %h want %h", got, e); end
        // Next START lands in the first IDLE cycle after FIN.
        run_op(1'b0, 1'b0, 5'd31, 32'h0000_0003, 1'b0, got, lat, bn);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL b2b_second got %h want %h", got, e); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_latency got %0d want 5", lat); end
    endtask

    task automatic test_random();
        logic [31:0] got, e;
        int lat, bn;
        for (int i = 0; i < 10; i++) begin
            run_op(1'($urandom), 1'($urandom), 5'($urandom), $urandom, 1'b0, got, lat, bn);
            e = exp_q.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL random_%0d got %h want %h", i, got, e); end
            checks++; if (lat !== 5) begin errors++; $display("FAIL random_lat_%0d got %0d want 5", i, lat); end
        end
    endtask

`ifdef SHIFT_SEQ_ROTATE_EN
    task automatic test_rotate();
        logic [31:0] got, e;
        int lat, bn;
        ROT = 1'b1;
        run_op(1'b1, 1'b0, 5'd1, 32'h0000_0001, 1'b0, got, lat, bn);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL rotate_right got %h want %h", got, e); end
        run_op(1'b0, 1'b1, 5'd4, 32'hF000_000F, 1'b0, got, lat, bn);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL rotate_left got %h want %h", got, e); end
        ROT = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_left();
        test_right();
        test_amt0();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
`ifdef SHIFT_SEQ_ROTATE_EN
        test_rotate();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
